// File: rtl/spm_bank_request_sequencer.sv
// rtl/spm_bank_request_sequencer.sv - per-bank lane request serializer for one SPM bank
// Optional SM_BSU_COALESCE_EN: lanes sharing an offset are served by one bank access.
module spm_bank_request_sequencer #(
  parameter int unsigned BANK_ADDRESS = 0,
  parameter int unsigned LANES        = 16,
  parameter int unsigned BANK_IDX_W   = 4,
  parameter int unsigned OFFSET_W     = 10,
  parameter int unsigned DATA_W       = 32,
  localparam int unsigned BE_W        = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_is_store,
  input  logic [LANES-1:0]             req_mask,
  input  logic [LANES*BANK_IDX_W-1:0]  req_bank_indexes,
  input  logic [LANES*OFFSET_W-1:0]    req_offsets,
  input  logic [LANES*DATA_W-1:0]      req_data,
  input  logic [LANES*BE_W-1:0]        req_byte_mask,
  output logic                         bank_enable,
  output logic                         bank_write,
  output logic [OFFSET_W-1:0]          bank_offset,
  output logic [DATA_W-1:0]            bank_data,
  output logic [BE_W-1:0]              bank_byte_mask,
  input  logic [DATA_W-1:0]            bank_read_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [LANES-1:0]             resp_lane_mask,
  output logic [LANES*DATA_W-1:0]      resp_data
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BANK_IDX_W-1:0] BANK_SEL = BANK_IDX_W'(BANK_ADDRESS);

  typedef enum logic [1:0] {IDLE, SERVE, DRAIN, RESP} state_t;

  state_t                          state, state_next;
  logic [LANES-1:0]                pending, req_pending, group;
  logic                            is_store_r;
  logic [LANES-1:0][OFFSET_W-1:0]  offsets_r;
  logic [LANES-1:0][DATA_W-1:0]    data_r;
  logic [LANES-1:0][BE_W-1:0]      be_r;
  logic [LANES-1:0]                lane_mask_r;
  logic [LANES-1:0][DATA_W-1:0]    resp_data_r;
  logic                            rd_valid;
  logic [LANES-1:0]                rd_group;
  logic [LANE_W-1:0]               sel_idx;
  logic                            sel_found;
  logic [DATA_W-1:0]               issue_data;
  logic [BE_W-1:0]                 issue_mask;
  logic                            serving, accept;

  always_comb begin
    req_pending = '0;
    for (int i = 0; i < LANES; i++)
      req_pending[i] = req_mask[i] && (req_bank_indexes[i*BANK_IDX_W +: BANK_IDX_W] == BANK_SEL);
  end

  // Lowest pending lane leads each access, giving ascending lane order.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!sel_found && pending[i]) begin
        sel_idx   = LANE_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    group      = '0;
    issue_data = '0;
    issue_mask = '0;
`ifdef SM_BSU_COALESCE_EN
    // Ascending scan lets the highest enabling lane win each byte.
    for (int i = 0; i < LANES; i++) begin
      if (pending[i] && (offsets_r[i] == offsets_r[sel_idx])) begin
        group[i]   = 1'b1;
        issue_mask = issue_mask | be_r[i];
        for (int b = 0; b < BE_W; b++)
          if (be_r[i][b]) issue_data[b*8 +: 8] = data_r[i][b*8 +: 8];
      end
    end
`else
    group[sel_idx] = sel_found;
    issue_data     = data_r[sel_idx];
    issue_mask     = be_r[sel_idx];
`endif
  end

  assign serving        = (state == SERVE) && sel_found;
  assign accept         = (state == IDLE) && req_valid;
  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign bank_enable    = serving;
  assign bank_write     = serving && is_store_r;
  assign bank_offset    = serving ? offsets_r[sel_idx] : '0;
  assign bank_data      = serving ? issue_data : '0;
  assign bank_byte_mask = serving ? issue_mask : '0;
  assign resp_lane_mask = lane_mask_r;
  assign resp_data      = resp_data_r;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (|req_pending) ? SERVE : RESP;
      SERVE:   if ((pending & ~group) == '0) state_next = DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      is_store_r  <= 1'b0;
      offsets_r   <= '0;
      data_r      <= '0;
      be_r        <= '0;
      lane_mask_r <= '0;
      resp_data_r <= '0;
      rd_valid    <= 1'b0;
      rd_group    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        pending     <= req_pending;
        lane_mask_r <= req_pending;
        resp_data_r <= '0;
        is_store_r  <= req_is_store;
        offsets_r   <= req_offsets;
        data_r      <= req_data;
        be_r        <= req_byte_mask;
      end else if (serving) begin
        pending <= pending & ~group;
      end
      // Bank returns read data the cycle after the access; capture it then.
      rd_valid <= serving && !is_store_r;
      rd_group <= group;
      if (rd_valid) begin
        for (int i = 0; i < LANES; i++)
          if (rd_group[i]) resp_data_r[i] <= bank_read_data;
      end
    end
  end

endmodule

// File: tb/tb_spm_bank_request_sequencer.sv
// tb/tb_spm_bank_request_sequencer.sv - directed bench with per-cycle expectation queue
module tb_spm_bank_request_sequencer;

`ifdef SM_BSU_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  localparam logic [3:0] BANK = 4'd0;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_is_store;
  logic [15:0]  req_mask;
  logic [63:0]  req_bank_indexes;
  logic [159:0] req_offsets;
  logic [511:0] req_data;
  logic [63:0]  req_byte_mask;
  logic         bank_enable, bank_write;
  logic [9:0]   bank_offset;
  logic [31:0]  bank_data;
  logic [3:0]   bank_byte_mask;
  logic [31:0]  bank_read_data;
  logic         resp_valid, resp_ready;
  logic [15:0]  resp_lane_mask;
  logic [511:0] resp_data;

  spm_bank_request_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_mask(req_mask), .req_bank_indexes(req_bank_indexes), .req_offsets(req_offsets),
    .req_data(req_data), .req_byte_mask(req_byte_mask),
    .bank_enable(bank_enable), .bank_write(bank_write), .bank_offset(bank_offset),
    .bank_data(bank_data), .bank_byte_mask(bank_byte_mask), .bank_read_data(bank_read_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_lane_mask(resp_lane_mask), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // Bank: synchronous read returning offset + 100.
  always @(posedge clk)
    if (bank_enable && !bank_write) bank_read_data <= 32'(bank_offset) + 32'd100;

  typedef struct packed {
    logic         wr;
    logic [9:0]   off;
    logic [31:0]  data;
    logic [3:0]   be;
  } acc_t;

  typedef struct packed {
    logic         en;
    acc_t         acc;
    logic         rv, rr, chk_resp;
    logic [15:0]  lm;
    logic [511:0] rd;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  logic        t_store;
  logic [15:0] t_mask;
  logic [3:0]  t_bank [16];
  logic [9:0]  t_off  [16];
  logic [31:0] t_data [16];
  logic [3:0]  t_be   [16];

  acc_t               acc_q [$];
  exp_t               exp_q [$];
  logic [15:0]        exp_lm;
  logic [15:0][31:0]  exp_rd;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req_ready", req_ready, e.rr);
      chk("bank_enable", bank_enable, e.en);
      chk("resp_valid", resp_valid, e.rv);
      if (e.en) begin
        chk("bank_write", bank_write, e.acc.wr);
        chk("bank_offset", bank_offset, e.acc.off);
        chk("bank_data", bank_data, e.acc.data);
        chk("bank_byte_mask", bank_byte_mask, e.acc.be);
      end
      if (e.chk_resp) begin
        chk("resp_lane_mask", resp_lane_mask, e.lm);
        chk("resp_data", resp_data, e.rd);
      end
    end
  end

  task automatic clear_req();
    t_store = 1'b0;
    t_mask  = '0;
    for (int i = 0; i < 16; i++) begin
      t_bank[i] = 4'd0;
      t_off[i]  = 10'(i + 40);
      t_data[i] = 32'hC0DE0000 + 32'(i);
      t_be[i]   = 4'hF;
    end
  endtask

  // Access list from the rules: lowest pending lane leads, its offset-mates join when coalescing.
  task automatic build_model(output int n);
    logic [15:0] pend, grp;
    acc_t a;
    int l;
    acc_q.delete();
    pend = '0;
    for (int i = 0; i < 16; i++) if (t_mask[i] && t_bank[i] == BANK) pend[i] = 1'b1;
    exp_lm = pend;
    for (int i = 0; i < 16; i++)
      exp_rd[i] = (pend[i] && !t_store) ? 32'(t_off[i]) + 32'd100 : 32'd0;
    while (pend != 0) begin
      l = 0;
      while (!pend[l]) l++;
      grp = '0;
      for (int j = 0; j < 16; j++)
        if (pend[j] && (j == l || (COAL && t_off[j] == t_off[l]))) grp[j] = 1'b1;
      a = '0;
      a.wr  = t_store;
      a.off = t_off[l];
      if (COAL) begin
        for (int j = 0; j < 16; j++)
          if (grp[j]) begin
            a.be = a.be | t_be[j];
            for (int b = 0; b < 4; b++) if (t_be[j][b]) a.data[b*8 +: 8] = t_data[j][b*8 +: 8];
          end
      end else begin
        a.data = t_data[l];
        a.be   = t_be[l];
      end
      acc_q.push_back(a);
      pend = pend & ~grp;
    end
    n = acc_q.size();
  endtask

  task automatic push_e(input logic en, input int ai, input logic rv, input logic rr, input logic cr);
    exp_t e;
    e = '0;
    e.en = en;
    if (en) e.acc = acc_q[ai];
    e.rv = rv;
    e.rr = rr;
    e.chk_resp = cr;
    if (cr && rv) begin
      e.lm = exp_lm;
      e.rd = exp_rd;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_req();
    req_is_store = t_store;
    req_mask     = t_mask;
    for (int i = 0; i < 16; i++) begin
      req_bank_indexes[i*4 +: 4] = t_bank[i];
      req_offsets[i*10 +: 10]    = t_off[i];
      req_data[i*32 +: 32]       = t_data[i];
      req_byte_mask[i*4 +: 4]    = t_be[i];
    end
  endtask

  // Cycle 0 presents the request; its closing edge is the accept edge.
  task automatic run_req(input int n, input int hold, input bit early);
    int rs;
    rs = (n == 0) ? 1 : n + 2;
    @(posedge clk); #1;
    drive_req();
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    push_e(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= n; c++) push_e(1'b1, c - 1, 1'b0, 1'b0, 1'b0);
    if (n > 0) push_e(1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int c = rs; c <= rs + hold; c++) push_e(1'b0, 0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= rs + hold; c++) begin
      @(posedge clk); #1;
      req_valid  = 1'b0;
      resp_ready = early ? 1'b1 : (c >= rs + hold);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; bank_read_data = '0;
    clear_req();
    drive_req();
    push_e(1'b0, 0, 1'b0, 1'b1, 1'b1);
    push_e(1'b0, 0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Load, four lanes on bank 0.
    clear_req();
    t_mask = 16'h000F;
    t_off[0] = 10'd3; t_off[1] = 10'd7; t_off[2] = 10'd1; t_off[3] = 10'd9;
    build_model(n);
    chk("pin_t1_n", 32'(n), 32'd4);
    chk("pin_t1_off", {acc_q[0].off, acc_q[1].off, acc_q[2].off, acc_q[3].off},
        {10'd3, 10'd7, 10'd1, 10'd9});
    chk("pin_t1_rd", {exp_rd[0], exp_rd[1], exp_rd[2], exp_rd[3]},
        {32'd103, 32'd107, 32'd101, 32'd109});
    run_req(n, 0, 1'b0);

    // No lane on this bank: straight to response.
    clear_req();
    t_mask = 16'h00FF;
    for (int i = 0; i < 16; i++) t_bank[i] = 4'd2;
    build_model(n);
    chk("pin_t2_n", 32'(n), 32'd0);
    run_req(n, 0, 1'b0);

    // Store, lanes 1,4,6 on bank 0, response held off for 5 cycles.
    clear_req();
    t_store = 1'b1;
    t_mask  = 16'h8057;
    for (int i = 0; i < 16; i++) t_bank[i] = 4'd3;
    t_bank[1] = 4'd0; t_bank[4] = 4'd0; t_bank[6] = 4'd0; t_bank[8] = 4'd0;
    t_off[1] = 10'd20; t_off[4] = 10'd11; t_off[6] = 10'd33;
    t_be[4] = 4'h5; t_be[6] = 4'h8;
    build_model(n);
    chk("pin_t3_n", 32'(n), 32'd3);
    chk("pin_t3_off", {acc_q[0].off, acc_q[1].off, acc_q[2].off}, {10'd20, 10'd11, 10'd33});
    chk("pin_t3_lm", exp_lm, 16'h0052);
    run_req(n, 5, 1'b0);

    // Two stores to the same offset.
    clear_req();
    t_store = 1'b1;
    t_mask  = 16'h0003;
    t_off[0] = 10'd5; t_off[1] = 10'd5;
    t_be[0] = 4'h3; t_be[1] = 4'h6;
    t_data[0] = 32'hAAAAAAAA; t_data[1] = 32'hBBBBBBBB;
    build_model(n);
    chk("pin_t4_n", 32'(n), COAL ? 32'd1 : 32'd2);
    chk("pin_t4_be", acc_q[0].be, COAL ? 4'h7 : 4'h3);
    chk("pin_t4_data", acc_q[0].data, COAL ? 32'h00BBBBAA : 32'hAAAAAAAA);
    run_req(n, 0, 1'b0);

    // Load with repeated offsets; resp_ready raised early.
    clear_req();
    t_mask = 16'h000F;
    t_off[0] = 10'd2; t_off[1] = 10'd2; t_off[2] = 10'd8; t_off[3] = 10'd2;
    build_model(n);
    chk("pin_t5_n", 32'(n), COAL ? 32'd2 : 32'd4);
    chk("pin_t5_rd", {exp_rd[0], exp_rd[1], exp_rd[2], exp_rd[3]},
        {32'd102, 32'd102, 32'd108, 32'd102});
    run_req(n, 0, 1'b1);

    // Reset in cycle 3 after two read issues.
    clear_req();
    t_mask = 16'h000F;
    t_off[0] = 10'd4; t_off[1] = 10'd5; t_off[2] = 10'd6; t_off[3] = 10'd7;
    build_model(n);
    @(posedge clk); #1;
    drive_req();
    req_valid = 1'b1; resp_ready = 1'b0;
    push_e(1'b0, 0, 1'b0, 1'b1, 1'b0);
    push_e(1'b1, 0, 1'b0, 1'b0, 1'b0);
    push_e(1'b1, 1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    push_e(1'b0, 0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) push_e(1'b0, 0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Normal request after the abort.
    clear_req();
    t_mask = 16'h0009;
    t_off[0] = 10'd12; t_off[3] = 10'd0;
    build_model(n);
    run_req(n, 1, 1'b0);

    repeat (3) @(posedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spm_bank_request_sequencer.md
# spm_bank_request_sequencer

Sequential per-bank front end for the scratchpad memory. It accepts one full lane-vector request, filters the lanes whose bank index equals `BANK_ADDRESS`, and issues them to a single-ported synchronous bank one access per cycle in ascending lane order, so bank conflicts are serialized instead of dropped. It collects load data per lane and returns the whole vector through a valid/ready response. One instance sits between the lane-address decode stage and each SPM bank.

## Interface
- `BANK_ADDRESS`, 0: bank index this instance serves.
- `LANES`, 16: number of processing-element lanes.
- `BANK_IDX_W`, 4: width of a lane's bank index.
- `OFFSET_W`, 10: width of an entry offset inside the bank.
- `DATA_W`, 32: word width. Byte-mask width `BE_W = DATA_W/8`.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_is_store` in 1: whole request is a store (1) or a load (0).
- `req_mask` in LANES: lane active.
- `req_bank_indexes` in LANES×BANK_IDX_W: per-lane bank index.
- `req_offsets` in LANES×OFFSET_W: per-lane entry offset.
- `req_data` in LANES×DATA_W: per-lane store data.
- `req_byte_mask` in LANES×BE_W: per-lane byte enables.
- `bank_enable` out 1: bank access this cycle.
- `bank_write` out 1: access is a write.
- `bank_offset` out OFFSET_W: entry offset.
- `bank_data` out DATA_W: write data.
- `bank_byte_mask` out BE_W: write byte enables.
- `bank_read_data` in DATA_W: read data, valid one cycle after a read access.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: response consumed.
- `resp_lane_mask` out LANES: lanes served by this bank.
- `resp_data` out LANES×DATA_W: per-lane load data.

## Operation
- States: IDLE, SERVE, DRAIN, RESP. `req_ready` = (state == IDLE).
- On accept, the block registers all request fields. `pending = req_mask & (bank_index == BANK_ADDRESS)`, `resp_lane_mask = pending`, and `resp_data` is cleared to 0.
- IDLE transitions on accept: to SERVE if `pending != 0`, otherwise directly to RESP.
- SERVE, each cycle:
  - Select the lowest set bit of `pending`.
  - Drive `bank_enable=1`, `bank_write=req_is_store`, and that lane's offset, data and byte mask.
  - Clear the lane's bit in `pending`.
  - When this issue empties `pending`, go to DRAIN.
- Read capture: the lane group issued by a read is registered. On the next cycle `bank_read_data` is written into `resp_data` for every lane in that group. Stores leave `resp_data` at 0.
- DRAIN: one cycle with no bank access, which completes the final read capture. Then go to RESP.
- RESP: hold `resp_valid=1` and stable outputs until `resp_ready`. On the handshake cycle go to IDLE. A new request is accepted no earlier than the following cycle.
- `bank_enable` is 0 in every state other than SERVE.

## Timing
- Reset value of every output is 0, except `req_ready`, which is 1. Reset sets state to IDLE and clears `pending` and the read pipeline.
- Reset mid-operation aborts the request. The bank sees no access after `reset` rises. A read already in flight is discarded.
- Call the accept edge cycle 0 and let N be the number of accesses issued:
  - Accesses occur in cycles 1..N.
  - DRAIN is cycle N+1.
  - `resp_valid` first rises in cycle N+2.
- For N = 0, `resp_valid` rises in cycle 1 and no bank access occurs.
- `resp_ready` held high gives a throughput of one request per N+3 cycles (N ≥ 1).
- `resp_ready` asserted before `resp_valid` has no effect.

## Configuration
- `SM_BSU_COALESCE_EN` defined: each SERVE issue also serves every pending lane whose offset equals the selected lane's offset, and clears all of them from `pending` together.
  - Loads: the single read word is written to every lane in the group.
  - Stores: `bank_byte_mask` is the OR of the group's masks. Each byte of `bank_data` comes from the highest-indexed lane in the group that enables that byte.
  - N becomes the number of distinct offsets among the served lanes.
- Not defined: exactly one lane per access, and N = popcount(`resp_lane_mask`).

## Test plan
- `BANK_ADDRESS`=0, load, `req_mask`=0xF, all bank 0, offsets 3,7,1,9, bank returns offset+100 -> accesses at offsets 3,7,1,9 in cycles 1–4; `resp_valid` in cycle 6; `resp_data` lanes 0–3 = 103,107,101,109; `resp_lane_mask`=0xF.
- `req_mask`=0xFF, all lanes bank 2 -> no `bank_enable`; `resp_valid` in cycle 1; `resp_lane_mask`=0; `resp_data`=0.
- Mixed banks with lanes 1,4,6 on bank 0, store -> three writes in lane order 1,4,6; `resp_valid` in cycle 5. `resp_ready` held low 5 cycles -> `resp_valid` and outputs hold, `req_ready`=0 throughout.
- Coalesce: store, lane 0 offset 5 mask 0x3 data 0xAAAAAAAA, lane 1 offset 5 mask 0x6 data 0xBBBBBBBB.
  - With macro: one write, mask 0x7, data 0x00BBBBAA.
  - Without macro: two writes.
- Load with 4 lanes; `reset` pulsed in cycle 3 (after 2 issues) -> `bank_enable`=0 from reset onward, `resp_valid` never rises, `req_ready`=1. A new request afterwards completes normally.
